contador_de_programa_pilha: RTL and testbench

Parametrised program counter with an integrated return-address stack: the next-generation PC of the ReduxV core. Advances by a fixed step each cycle; supports stall, branch/jump load, call (push return address and jump) and return (pop and jump). Sits in the fetch stage and drives the instruction-memory address. Overflow and underflow error flags are sticky.

---
 rtl/contador_de_programa_pilha.sv | 118 +++++++++++
 tb/tb_contador_de_programa_pilha.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/contador_de_programa_pilha.sv
// contador_de_programa_pilha
// Fetch-stage program counter with an integrated return-address stack.
// The PC advances by STEP each cycle. It supports stall, branch load, call
// (push return address and jump) and return (pop and jump). The overflow
// and underflow flags are sticky until rst.
// Optional feature macro: PC_STACK_WRAP_EN. When it is defined, a call on a
// full stack overwrites the oldest entry. When it is undefined, the return
// address of that call is dropped.
module contador_de_programa_pilha #(
    parameter int WIDTH = 8,
    parameter int STEP  = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] curr_pc,
    output logic [WIDTH-1:0] next_pc,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // wr_ptr points at the slot the next push will write. The top entry
    // sits one slot below it. The pointer wraps naturally because DEPTH is
    // a power of two, and that wrap is what makes the circular overwrite
    // land on the oldest entry.
    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] top_entry;
    logic             is_empty;
    logic             is_full;
    logic             do_pop;
    logic             do_call;
    logic             write_en;

    // Next-PC selection and stack bookkeeping, using the priority order stall > ret > call > branch > increment
    always_comb begin
        seq_pc     = curr_pc + WIDTH'(STEP);
        is_empty   = (count == '0);
        is_full    = (count == CNT_W'(DEPTH));
        top_entry  = stack_mem[wr_ptr - PTR_W'(1)];
        do_pop     = !stall && ret && !is_empty;
        do_call    = !stall && !ret && call;
`ifdef PC_STACK_WRAP_EN
        write_en   = do_call;
`else
        write_en   = do_call && !is_full;
`endif

        next_pc = seq_pc;
        if (stall) begin
            next_pc = curr_pc;
        end else if (ret) begin
            next_pc = is_empty ? seq_pc : top_entry;
        end else if (call || branch_en) begin
            next_pc = branch_target;
        end

        count_next = count;
        ptr_next   = wr_ptr;
        if (do_pop) begin
            count_next = count - CNT_W'(1);
            ptr_next   = wr_ptr - PTR_W'(1);
        end else if (write_en) begin
            ptr_next = wr_ptr + PTR_W'(1);
            if (!is_full) begin
                count_next = count + CNT_W'(1);
            end
        end
    end

    // PC, stack pointer, occupancy flags and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_pc     <= RESET_PC;
            wr_ptr      <= '0;
            count       <= '0;
            stack_empty <= 1'b1;
            stack_full  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            curr_pc     <= next_pc;
            wr_ptr      <= ptr_next;
            count       <= count_next;
            stack_empty <= (count_next == '0);
            stack_full  <= (count_next == CNT_W'(DEPTH));
            if (do_call && is_full) begin
                overflow <= 1'b1;
            end
            if (!stall && ret && is_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Return-address storage; contents are meaningless after reset, so no reset here
    always_ff @(posedge clk) begin
        if (!rst && write_en) begin
            stack_mem[wr_ptr] <= seq_pc;
        end
    end

endmodule

// File: tb/tb_contador_de_programa_pilha.sv
// tb_contador_de_programa_pilha
// Directed and randomized stimulus checked against a queue-based model of
// the program counter and its return stack. Honours PC_STACK_WRAP_EN.
module tb_contador_de_programa_pilha;

    localparam int W     = 8;
    localparam int STEP  = 4;
    localparam int DEPTH = 4;
    localparam logic [W-1:0] RST_PC = 8'h00;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         branch_en;
    logic [W-1:0] branch_target;
    logic         call;
    logic         ret;
    logic [W-1:0] curr_pc;
    logic [W-1:0] next_pc;
    logic         stack_empty;
    logic         stack_full;
    logic         overflow;
    logic         underflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model state: PC, LIFO of return addresses (back = top), sticky flags
    logic [W-1:0] m_pc;
    logic [W-1:0] m_q[$];
    logic         m_ovf;
    logic         m_udf;
    logic         model_valid = 1'b0;

    contador_de_programa_pilha #(
        .WIDTH(W), .STEP(STEP), .RESET_PC(RST_PC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .call(call), .ret(ret),
        .curr_pc(curr_pc), .next_pc(next_pc), .stack_empty(stack_empty),
        .stack_full(stack_full), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, hold them across the edge, return just after it
    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input logic [W-1:0] t, input logic c, input logic rt);
        rst = r; stall = s; branch_en = b; branch_target = t; call = c; ret = rt;
        @(posedge clk);
        #1;
    endtask

    // The PC the model expects after the coming edge (no reset)
    function automatic logic [W-1:0] model_next();
        logic [W-1:0] seq;
        seq = m_pc + W'(STEP);
        if (stall) return m_pc;
        if (ret) return (m_q.size() > 0) ? m_q[m_q.size()-1] : seq;
        if (call || branch_en) return branch_target;
        return seq;
    endfunction

    // Advance the model on each edge
    always @(posedge clk) begin
        logic [W-1:0] nxt;
        logic [W-1:0] ret_addr;
        if (rst) begin
            m_pc = RST_PC;
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid && !stall) begin
            nxt = model_next();
            ret_addr = m_pc + W'(STEP);
            if (ret) begin
                if (m_q.size() > 0) void'(m_q.pop_back());
                else m_udf = 1'b1;
            end else if (call) begin
                if (m_q.size() == DEPTH) begin
                    m_ovf = 1'b1;
`ifdef PC_STACK_WRAP_EN
                    void'(m_q.pop_front());
                    m_q.push_back(ret_addr);
`endif
                end else begin
                    m_q.push_back(ret_addr);
                end
            end
            m_pc = nxt;
        end
    end

    // Compare the DUT against the model on every falling edge
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("curr_pc", 32'(curr_pc), 32'(m_pc));
            checkOutput("next_pc", 32'(next_pc), 32'(model_next()));
            checkOutput("stack_empty", 32'(stack_empty), 32'(m_q.size() == 0));
            checkOutput("stack_full", 32'(stack_full), 32'(m_q.size() == DEPTH));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("underflow", 32'(underflow), 32'(m_udf));
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = '0; call = 1'b0; ret = 1'b0;

        // Reset, then free-run 0 -> 4 -> 8 -> 12
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        checkOutput("lit_reset_pc", 32'(curr_pc), 32'h00);
        checkOutput("lit_reset_empty", 32'(stack_empty), 32'h1);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("lit_run1", 32'(curr_pc), 32'h04);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("lit_run2", 32'(curr_pc), 32'h08);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("lit_run3", 32'(curr_pc), 32'h0C);
        checkOutput("lit_run3_flags", 32'({overflow, underflow, stack_full}), 32'h0);

        // Wrap from 0xFC to 0x00, then a two-cycle stall
        applyStimulus(0, 0, 1, 8'hFC, 0, 0);
        checkOutput("lit_branch_fc", 32'(curr_pc), 32'hFC);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("lit_wrap", 32'(curr_pc), 32'h00);
        applyStimulus(0, 1, 1, 8'h77, 1, 0);
        applyStimulus(0, 1, 0, 8'h00, 0, 1);
        checkOutput("lit_stall", 32'(curr_pc), 32'h00);

        // Call at pc=8 to 0x40, then return to 0x0C
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 8'h40, 1, 0);
        checkOutput("lit_call_pc", 32'(curr_pc), 32'h40);
        checkOutput("lit_call_empty", 32'(stack_empty), 32'h0);
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        checkOutput("lit_ret_pc", 32'(curr_pc), 32'h0C);
        checkOutput("lit_ret_empty", 32'(stack_empty), 32'h1);

        // Five nested calls from pc=0; return addresses pushed are 04,14,24,34,44
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 5; i++) applyStimulus(0, 0, 0, W'(i * 16), 1, 0);
        checkOutput("lit_nest_ovf", 32'(overflow), 32'h1);
        checkOutput("lit_nest_full", 32'(stack_full), 32'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0, 1);
`ifdef PC_STACK_WRAP_EN
            checkOutput("lit_nest_ret", 32'(curr_pc), 32'(8'h44 - 8'(i * 16)));
`else
            checkOutput("lit_nest_ret", 32'(curr_pc), 32'(8'h34 - 8'(i * 16)));
`endif
        end

        // Return on an empty stack at pc=0x20
        applyStimulus(0, 0, 1, 8'h20, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        checkOutput("lit_udf_pc", 32'(curr_pc), 32'h24);
        checkOutput("lit_udf_flag", 32'(underflow), 32'h1);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 1, 8'h50, 0, 0);
        checkOutput("lit_udf_sticky", 32'(underflow), 32'h1);

        // Top = 0x18, then call+ret+branch together: return wins
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 1, 8'h14, 0, 0);
        applyStimulus(0, 0, 0, 8'h60, 1, 0);
        applyStimulus(0, 0, 1, 8'h80, 1, 1);
        checkOutput("lit_combo_pc", 32'(curr_pc), 32'h18);
        checkOutput("lit_combo_empty", 32'(stack_empty), 32'h1);

        // Reset with three entries on the stack
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h30, 1, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h90, 1, 0);
        applyStimulus(1, 0, 0, 8'h00, 1, 1);
        checkOutput("lit_rst_pc", 32'(curr_pc), 32'h00);
        checkOutput("lit_rst_flags", 32'({stack_empty, stack_full, overflow, underflow}), 32'h8);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            applyStimulus(logic'($urandom_range(0, 59) == 0),
                          logic'($urandom_range(0, 6) == 0),
                          logic'($urandom_range(0, 3) == 0),
                          W'($urandom),
                          logic'($urandom_range(0, 2) == 0),
                          logic'($urandom_range(0, 3) == 0));
        end
        applyStimulus(0, 0, 0, 8'h00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
